// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding imem request, one-entry skid buffer
// toward decode, redirect flush with response drop.
// Optional feature macro: IF_MISALIGN_CHECK_EN (misaligned redirect halts fetch).
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_stall,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic        misalign
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP  = 32'd4;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t          state_q;
    logic            req_q;
    logic            halt_q;
    logic            id_valid_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pend_pc_q;
    logic [XLEN-1:0] skid_inst_q;
    logic [XLEN-1:0] skid_pc_q;
    logic [XLEN-1:0] id_inst_q;
    logic [XLEN-1:0] id_pc_q;
    logic [XLEN-1:0] id_pc4_q;
    logic            redir_bad_c;

`ifdef IF_MISALIGN_CHECK_EN
    // A redirect target that is not word aligned is fatal to fetch.
    assign redir_bad_c = |redirect_pc[1:0];
    assign misalign    = halt_q;
`else
    // Low target bits are dropped; the pc is always word aligned.
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];
    assign redir_bad_c         = 1'b0;
    assign misalign            = 1'b0;
`endif

    assign imem_req  = req_q;
    assign imem_addr = {pc_q[XLEN-1:2], 2'b00};
    assign id_valid  = id_valid_q;
    assign id_inst   = id_inst_q;
    assign id_pc     = id_pc_q;
    assign id_pc4    = id_pc4_q;

    // Fetch FSM: request handshake, response delivery/skid, redirect flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_REQ;
            req_q       <= 1'b1;
            halt_q      <= 1'b0;
            id_valid_q  <= 1'b0;
            pc_q        <= {RESET_PC[XLEN-1:2], 2'b00};
            pend_pc_q   <= '0;
            skid_inst_q <= '0;
            skid_pc_q   <= '0;
            id_inst_q   <= NOP_INST;
            id_pc_q     <= '0;
            id_pc4_q    <= '0;
        end else begin
            // Decode consumed the held instruction; later loads override this.
            if (id_valid_q && !id_stall) begin
                id_valid_q <= 1'b0;
            end

            if (halt_q) begin
                req_q      <= 1'b0;
                id_valid_q <= 1'b0;
            end else if (redirect_valid) begin
                id_valid_q <= 1'b0;
                if (redir_bad_c) begin
                    halt_q  <= 1'b1;
                    req_q   <= 1'b0;
                    state_q <= S_REQ;
                end else begin
                    pc_q <= {redirect_pc[XLEN-1:2], 2'b00};
                    // An in-flight response that has not yet returned must be dropped.
                    if ((state_q == S_WAIT || state_q == S_DROP) && !imem_rvalid) begin
                        state_q <= S_DROP;
                        req_q   <= 1'b0;
                    end else begin
                        state_q <= S_REQ;
                        req_q   <= 1'b1;
                    end
                end
            end else begin
                case (state_q)
                    S_REQ: begin
                        if (imem_ready) begin
                            pend_pc_q <= pc_q;
                            state_q   <= S_WAIT;
                            req_q     <= 1'b0;
                        end
                    end
                    S_WAIT: begin
                        if (imem_rvalid) begin
                            pc_q <= pend_pc_q + PC_STEP;
                            if (!id_valid_q || !id_stall) begin
                                id_inst_q  <= imem_rdata;
                                id_pc_q    <= pend_pc_q;
                                id_pc4_q   <= pend_pc_q + PC_STEP;
                                id_valid_q <= 1'b1;
                                state_q    <= S_REQ;
                                req_q      <= 1'b1;
                            end else begin
                                skid_inst_q <= imem_rdata;
                                skid_pc_q   <= pend_pc_q;
                                state_q     <= S_HOLD;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (!id_stall) begin
                            id_inst_q  <= skid_inst_q;
                            id_pc_q    <= skid_pc_q;
                            id_pc4_q   <= skid_pc_q + PC_STEP;
                            id_valid_q <= 1'b1;
                            state_q    <= S_REQ;
                            req_q      <= 1'b1;
                        end
                    end
                    S_DROP: begin
                        if (imem_rvalid) begin
                            state_q <= S_REQ;
                            req_q   <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= S_REQ;
                        req_q   <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: scripted imem responses, scoreboard of delivered
// instructions checked whenever decode consumes one.
module tb_fetch_unit;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_stall = 1'b0;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic        misalign;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_stall(id_stall), .id_valid(id_valid), .id_inst(id_inst),
        .id_pc(id_pc), .id_pc4(id_pc4), .misalign(misalign)
    );

    always #5 clk = ~clk;

    // Advance one cycle; at the falling edge pop and compare any instruction decode takes.
    task automatic tick();
        exp_t  e;
        @(negedge clk);
        if (rst_n && id_valid && !id_stall) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: got inst=%h pc=%h, required no delivery", id_inst, id_pc);
            end else begin
                e = exp_q.pop_front();
                if (id_inst !== e.inst || id_pc !== e.pc || id_pc4 !== e.pc + 32'd4) begin
                    failures++;
                    $display("FAIL sb_deliver: got inst=%h pc=%h pc4=%h, required inst=%h pc=%h pc4=%h",
                             id_inst, id_pc, id_pc4, e.inst, e.pc, e.pc + 32'd4);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0;
        redirect_valid = 1'b0; id_stall = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One fetch transaction answered with data; rnd adds latency and random stalls.
    task automatic fetch(input logic [31:0] data, input bit rnd);
        int          n = 0;
        logic [31:0] a;
        exp_t        e;
        while (!imem_req && n < 50) begin
            if (rnd) id_stall = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        checks++;
        if (!imem_req) begin
            failures++;
            $display("FAIL req_timeout: got imem_req=%b, required 1 within 50 cycles", imem_req);
            return;
        end
        a = imem_addr;
        e.inst = data; e.pc = a;
        exp_q.push_back(e);
        if (rnd) begin
            repeat ($urandom_range(0, 2)) begin
                id_stall = 1'($urandom_range(0, 1));
                tick();
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== a) begin
                    failures++;
                    $display("FAIL req_stable: got req=%b addr=%h, required req=1 addr=%h", imem_req, imem_addr, a);
                end
            end
        end
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        if (rnd) begin
            repeat ($urandom_range(0, 2)) begin
                id_stall = 1'($urandom_range(0, 1));
                tick();
            end
            id_stall = 1'($urandom_range(0, 1));
        end
        imem_rvalid = 1'b1; imem_rdata = data;
        tick();
        imem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks += 7;
        if (imem_req !== 1'b1) begin failures++; $display("FAIL rst_req: got %b, required 1", imem_req); end
        if (imem_addr !== 32'h0) begin failures++; $display("FAIL rst_addr: got %h, required 00000000", imem_addr); end
        if (id_valid !== 1'b0) begin failures++; $display("FAIL rst_id_valid: got %b, required 0", id_valid); end
        if (id_inst !== 32'h0000_0013) begin failures++; $display("FAIL rst_id_inst: got %h, required 00000013", id_inst); end
        if (id_pc !== 32'h0) begin failures++; $display("FAIL rst_id_pc: got %h, required 00000000", id_pc); end
        if (id_pc4 !== 32'h0) begin failures++; $display("FAIL rst_id_pc4: got %h, required 00000000", id_pc4); end
        if (misalign !== 1'b0) begin failures++; $display("FAIL rst_misalign: got %b, required 0", misalign); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        fetch(32'h0050_0093, 1'b0);
        checks += 5;
        if (id_valid !== 1'b1) begin failures++; $display("FAIL basic_valid: got %b, required 1", id_valid); end
        if (id_pc !== 32'h0) begin failures++; $display("FAIL basic_pc: got %h, required 00000000", id_pc); end
        if (id_pc4 !== 32'h4) begin failures++; $display("FAIL basic_pc4: got %h, required 00000004", id_pc4); end
        if (imem_addr !== 32'h4) begin failures++; $display("FAIL basic_next_addr: got %h, required 00000004", imem_addr); end
        if (imem_req !== 1'b1) begin failures++; $display("FAIL basic_next_req: got %b, required 1", imem_req); end
    endtask

    task automatic test_stall();
        id_stall = 1'b1;
        fetch(32'h00A0_0113, 1'b0);
        checks += 3;
        if (id_inst !== 32'h0050_0093) begin failures++; $display("FAIL hold_inst: got %h, required 00500093", id_inst); end
        if (id_valid !== 1'b1) begin failures++; $display("FAIL hold_valid: got %b, required 1", id_valid); end
        if (imem_req !== 1'b0) begin failures++; $display("FAIL hold_req: got %b, required 0", imem_req); end
        tick(); tick();
        checks++;
        if (id_inst !== 32'h0050_0093) begin failures++; $display("FAIL hold_inst2: got %h, required 00500093", id_inst); end
        id_stall = 1'b0;
        tick();
        checks += 4;
        if (id_inst !== 32'h00A0_0113) begin failures++; $display("FAIL skid_inst: got %h, required 00a00113", id_inst); end
        if (id_pc !== 32'h4) begin failures++; $display("FAIL skid_pc: got %h, required 00000004", id_pc); end
        if (imem_addr !== 32'h8) begin failures++; $display("FAIL skid_next_addr: got %h, required 00000008", imem_addr); end
        if (imem_req !== 1'b1) begin failures++; $display("FAIL skid_next_req: got %b, required 1", imem_req); end
    endtask

    task automatic test_redirect_wait();
        imem_ready = 1'b1; tick(); imem_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0100; tick(); redirect_valid = 1'b0;
        checks += 2;
        if (imem_req !== 1'b0) begin failures++; $display("FAIL drop_req: got %b, required 0", imem_req); end
        if (id_valid !== 1'b0) begin failures++; $display("FAIL drop_valid: got %b, required 0", id_valid); end
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; tick(); imem_rvalid = 1'b0;
        checks += 3;
        if (imem_addr !== 32'h100) begin failures++; $display("FAIL drop_next_addr: got %h, required 00000100", imem_addr); end
        if (imem_req !== 1'b1) begin failures++; $display("FAIL drop_next_req: got %b, required 1", imem_req); end
        if (id_valid !== 1'b0) begin failures++; $display("FAIL drop_discard: got %b, required 0", id_valid); end
    endtask

    task automatic test_redirect_rvalid();
        imem_ready = 1'b1; tick(); imem_ready = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0BAD;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; tick();
        imem_rvalid = 1'b0; redirect_valid = 1'b0;
        checks += 3;
        if (id_valid !== 1'b0) begin failures++; $display("FAIL rr_valid: got %b, required 0", id_valid); end
        if (id_inst !== 32'h00A0_0113) begin failures++; $display("FAIL rr_inst: got %h, required 00a00113", id_inst); end
        if (imem_addr !== 32'h200) begin failures++; $display("FAIL rr_addr: got %h, required 00000200", imem_addr); end
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0300; tick(); redirect_valid = 1'b0;
        checks++;
        if (imem_addr !== 32'h300 || imem_req !== 1'b1) begin failures++; $display("FAIL req_redirect: got req=%b addr=%h, required req=1 addr=00000300", imem_req, imem_addr); end
        imem_ready = 1'b1; tick(); imem_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0400; tick();
        redirect_pc = 32'h0000_0500; tick(); redirect_valid = 1'b0;
        checks++;
        if (imem_req !== 1'b0) begin failures++; $display("FAIL drop_redirect_stay: got req=%b, required 0", imem_req); end
        imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111; tick(); imem_rvalid = 1'b0;
        checks++;
        if (imem_addr !== 32'h500 || imem_req !== 1'b1 || id_valid !== 1'b0) begin
            failures++;
            $display("FAIL drop_redirect_exit: got req=%b addr=%h valid=%b, required req=1 addr=00000500 valid=0", imem_req, imem_addr, id_valid);
        end
    endtask

    task automatic test_misalign();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0102; tick(); redirect_valid = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
        checks += 2;
        if (misalign !== 1'b1) begin failures++; $display("FAIL mis_flag: got %b, required 1", misalign); end
        if (imem_req !== 1'b0) begin failures++; $display("FAIL mis_req: got %b, required 0", imem_req); end
        imem_ready = 1'b1; tick(); tick(); imem_ready = 1'b0;
        checks++;
        if (imem_req !== 1'b0 || misalign !== 1'b1 || id_valid !== 1'b0) begin
            failures++;
            $display("FAIL mis_sticky: got req=%b mis=%b valid=%b, required req=0 mis=1 valid=0", imem_req, misalign, id_valid);
        end
`else
        checks += 3;
        if (imem_addr !== 32'h100) begin failures++; $display("FAIL mis_addr: got %h, required 00000100", imem_addr); end
        if (misalign !== 1'b0) begin failures++; $display("FAIL mis_flag: got %b, required 0", misalign); end
        if (imem_req !== 1'b1) begin failures++; $display("FAIL mis_req: got %b, required 1", imem_req); end
`endif
    endtask

    task automatic test_wrap();
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; tick(); redirect_valid = 1'b0;
        checks++;
        if (imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_addr: got %h, required fffffffc", imem_addr); end
        fetch(32'h1234_5678, 1'b0);
        checks += 3;
        if (id_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_pc: got %h, required fffffffc", id_pc); end
        if (id_pc4 !== 32'h0) begin failures++; $display("FAIL wrap_pc4: got %h, required 00000000", id_pc4); end
        if (imem_addr !== 32'h0) begin failures++; $display("FAIL wrap_next_addr: got %h, required 00000000", imem_addr); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) begin
            fetch($urandom, 1'b1);
        end
        id_stall = 1'b0;
        repeat (4) tick();
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL sb_leftover: got %0d undelivered, required 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_redirect_wait();
        test_redirect_rvalid();
        test_misalign();
        test_wrap();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
